// File: rtl/tick_generator.sv
// Multi-channel programmable tick / clock-enable generator. Each channel
// divides clk by a runtime divisor and emits a one-cycle pulse or a 50 % toggle.
module tick_generator #(
  parameter int                       NUM_CH    = 2,
  parameter int                       CNT_W     = 27,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT  = {27'd5_000, 27'd100_000_000},
  parameter logic [NUM_CH-1:0]        MODE_INIT = 2'b10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] clr,
  input  logic [NUM_CH-1:0] mode_set,
  input  logic [NUM_CH-1:0] mode_val,
  input  logic              div_load,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_value,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] div_pending
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [2:0]       CH_IDX   = 3'(i);
    localparam logic [CNT_W-1:0] D_RESET  = DIV_INIT[i*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] d_act_r;
    logic [CNT_W-1:0] d_shd_r;
    logic             pend_r;
    logic             mode_r;
    logic             pls_r;
    logic             tog_r;

    logic [CNT_W-1:0] cnt_n_s;
    logic [CNT_W-1:0] d_act_n_s;
    logic [CNT_W-1:0] d_shd_n_s;
    logic             pend_n_s;
    logic             mode_n_s;
    logic             pls_n_s;
    logic             tog_n_s;
    logic             halted_s;
    logic             wrap_s;
    logic             load_hit_s;

    // Channel index compare also rejects out-of-range div_ch values.
    assign load_hit_s = div_load && (div_ch == CH_IDX);
    assign halted_s   = (d_act_r == ZERO);
    assign wrap_s     = en[i] && !halted_s && (cnt_r >= (d_act_r - ONE));

    // Next-state: clear beats wrap beats count; loads go shadow or direct.
    always_comb begin
      cnt_n_s   = cnt_r;
      d_act_n_s = d_act_r;
      d_shd_n_s = d_shd_r;
      pend_n_s  = pend_r;
      pls_n_s   = 1'b0;
      tog_n_s   = tog_r;
      mode_n_s  = mode_set[i] ? mode_val[i] : mode_r;

      if (clr[i] || wrap_s) begin
        cnt_n_s = ZERO;
        if (clr[i]) begin
          pls_n_s = 1'b0;
          tog_n_s = 1'b0;
        end else begin
          pls_n_s = 1'b1;
          tog_n_s = ~tog_r;
        end
        if (load_hit_s) begin
          d_act_n_s = div_value;
          d_shd_n_s = div_value;
          pend_n_s  = 1'b0;
        end else if (pend_r) begin
          d_act_n_s = d_shd_r;
          pend_n_s  = 1'b0;
        end else begin
          pend_n_s  = 1'b0;
        end
      end else if (en[i]) begin
        if (halted_s) begin
          cnt_n_s = cnt_r;
        end else begin
          cnt_n_s = cnt_r + ONE;
        end
        if (load_hit_s) begin
          d_shd_n_s = div_value;
          pend_n_s  = 1'b1;
        end else begin
          pend_n_s  = pend_r;
        end
      end else begin
        if (load_hit_s) begin
          d_act_n_s = div_value;
          d_shd_n_s = div_value;
          pend_n_s  = 1'b0;
        end else begin
          pend_n_s  = pend_r;
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r   <= ZERO;
        d_act_r <= D_RESET;
        d_shd_r <= D_RESET;
        pend_r  <= 1'b0;
        mode_r  <= MODE_INIT[i];
        pls_r   <= 1'b0;
        tog_r   <= 1'b0;
      end else begin
        cnt_r   <= cnt_n_s;
        d_act_r <= d_act_n_s;
        d_shd_r <= d_shd_n_s;
        pend_r  <= pend_n_s;
        mode_r  <= mode_n_s;
        pls_r   <= pls_n_s;
        tog_r   <= tog_n_s;
      end
    end

    assign tick_out[i]    = mode_r ? tog_r : pls_r;
    assign div_pending[i] = pend_r;
  end

endmodule
